// File: rtl/acc_vec.sv
// acc_vec: multi-lane windowed saturating accumulator.
// Each closed window lands in a valid/ready result register.
module acc_vec #(
  parameter int IWIDTH = 16,
  parameter int AWIDTH = 32,
  parameter int LANES  = 4,
  parameter int CNTW   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic [CNTW-1:0]          i_len,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [LANES*IWIDTH-1:0]  i_data,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [LANES*AWIDTH-1:0]  o_data,
  output logic [LANES-1:0]         o_sat
);

  localparam logic [CNTW-1:0] ONE = CNTW'(1);

  logic [LANES-1:0][AWIDTH-1:0] acc;
  logic [LANES-1:0][AWIDTH-1:0] nxt;
  logic [LANES-1:0]             sat;
  logic [LANES-1:0]             sat_b;
  logic [CNTW-1:0]              cnt;
  logic [CNTW-1:0]              len_q;
  logic [CNTW-1:0]              len_in;
  logic [CNTW-1:0]              eff_len;
  logic                         last;
  logic                         fire;

  assign len_in  = (i_len == '0) ? ONE : i_len;
  assign eff_len = (cnt == '0) ? len_in : len_q;
  assign last    = (cnt == eff_len - ONE);
  // only the closing beat waits on a full, undrained result
  assign i_ready = ~clr & ~(last & o_valid & ~o_ready);
  assign fire    = i_valid & i_ready;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [IWIDTH-1:0] x;
    logic [AWIDTH:0]   s;
    assign x = i_data[k*IWIDTH +: IWIDTH];
    assign s = {{(AWIDTH+1-IWIDTH){x[IWIDTH-1]}}, x}
             + {acc[k][AWIDTH-1], acc[k]};
    // top two bits differ only when the sum left the AWIDTH range
    assign sat_b[k] = s[AWIDTH] ^ s[AWIDTH-1];
    assign nxt[k] = !sat_b[k] ? s[AWIDTH-1:0]
                  : s[AWIDTH] ? {1'b1, {(AWIDTH-1){1'b0}}}
                  :             {1'b0, {(AWIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      sat     <= '0;
      cnt     <= '0;
      len_q   <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_sat   <= '0;
    end else if (clr) begin
      acc     <= '0;
      sat     <= '0;
      cnt     <= '0;
      len_q   <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_sat   <= '0;
    end else begin
      if (o_valid && o_ready)
        o_valid <= 1'b0;
      if (fire) begin
        if (cnt == '0)
          len_q <= len_in;
        if (last) begin
          o_data  <= nxt;
          o_sat   <= sat | sat_b;
          o_valid <= 1'b1;
          acc     <= '0;
          sat     <= '0;
          cnt     <= '0;
        end else begin
          acc <= nxt;
          sat <= sat | sat_b;
          cnt <= cnt + ONE;
        end
      end
    end
  end

endmodule
